// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus single-outstanding instruction fetch for the RV32I core
module pc_fetch_unit #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PCsrc,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_ready,
    output logic            misalign_err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, next_pc;
    logic [31:0]     instr_q, instr_d;

    assign next_pc = PCsrc == 2'b01 ? pc_target
                   : PCsrc == 2'b10 ? {jalr_target[XLEN-1:1], 1'b0}
                   : pc_q + XLEN'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = imem_ready ? S_WAIT : S_REQ;
            S_WAIT: begin
                state_d = imem_rvalid ? S_HOLD : S_WAIT;
                instr_d = imem_rvalid ? imem_rdata : instr_q;
            end
            S_HOLD: if (instr_ready) begin
                state_d = |next_pc[1:0] ? S_ERR : S_REQ;
                pc_d    = |next_pc[1:0] ? pc_q : next_pc;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req     = state_q == S_REQ;
    assign imem_addr    = pc_q;
    assign instr_valid  = state_q == S_HOLD;
    assign misalign_err = state_q == S_ERR;
    assign instr        = instr_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + XLEN'(4);
endmodule
